// File: rtl/channel_feed_scheduler.sv
// Streams per-channel image planes from a synchronous RAM to a conv core,
// one pixel per FETCH/CAPTURE pair, skipping held or exhausted channels.
module channel_feed_scheduler #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int N_ROWS     = 100,
  parameter int N_COLS     = 100,
  parameter int N_CHANNELS = 3
) (
  input  logic                             clock_i,
  input  logic                             reset_n_i,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [N_CHANNELS-1:0]            hold_data_i,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic                             ram_rden_o,
  input  logic [DATA_WIDTH-1:0]            ram_data_i,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] data_o,
  output logic [N_CHANNELS-1:0]            data_valid_o,
  output logic [$clog2(N_CHANNELS):0]      channel_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int N_PIX = N_ROWS * N_COLS;
  localparam int PTR_W = $clog2(N_PIX + 1);
  localparam int CH_W  = $clog2(N_CHANNELS) + 1;

  if (64'(N_CHANNELS) * 64'(N_PIX) > (64'd1 << ADDR_WIDTH)) begin : g_cfg_err
    $error("channel_feed_scheduler: N_CHANNELS*N_PIX exceeds the RAM address space");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                            state_r;
  state_t                            state_next_s;
  logic [CH_W-1:0]                   channel_r;
  logic [CH_W-1:0]                   channel_next_s;
  logic [PTR_W-1:0]                  ptr_r [N_CHANNELS];
  logic [N_CHANNELS*DATA_WIDTH-1:0]  data_r;
  logic [N_CHANNELS-1:0]             valid_r;
  logic                              busy_r;
  logic                              done_r;

  logic [PTR_W-1:0]                  cur_ptr_s;
  logic                              cur_hold_s;
  logic                              cur_empty_s;
  logic                              all_empty_s;
  logic [ADDR_WIDTH-1:0]             addr_s;
  logic                              rd_s;
  logic                              load_s;
  logic                              advance_s;
  logic                              capture_s;

  // Select the served channel's pointer and hold bit; flag exhausted planes.
  always_comb begin
    cur_ptr_s   = {PTR_W{1'b0}};
    cur_hold_s  = 1'b0;
    all_empty_s = 1'b1;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (channel_r == CH_W'(c)) begin
        cur_ptr_s  = ptr_r[c];
        cur_hold_s = hold_data_i[c];
      end else begin
        cur_ptr_s  = cur_ptr_s;
      end
      if (ptr_r[c] != PTR_W'(N_PIX)) begin
        all_empty_s = 1'b0;
      end else begin
        all_empty_s = all_empty_s;
      end
    end
    cur_empty_s = (cur_ptr_s == PTR_W'(N_PIX));
    addr_s = ADDR_WIDTH'(channel_r) * ADDR_WIDTH'(N_PIX) + ADDR_WIDTH'(cur_ptr_s);
    if (channel_r == CH_W'(N_CHANNELS - 1)) begin
      channel_next_s = {CH_W{1'b0}};
    end else begin
      channel_next_s = channel_r + CH_W'(1);
    end
  end

  // Next-state and control decode; clear overrides every other action.
  always_comb begin
    state_next_s = state_r;
    rd_s         = 1'b0;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    capture_s    = 1'b0;
    if (clear_i) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            load_s       = 1'b1;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (all_empty_s) begin
            state_next_s = ST_DONE;
          end else if (cur_empty_s || cur_hold_s) begin
            advance_s    = 1'b1;
            state_next_s = ST_FETCH;
          end else begin
            rd_s         = 1'b1;
            state_next_s = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          capture_s    = 1'b1;
          state_next_s = ST_FETCH;
        end
        ST_DONE: begin
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, channel, pointers and registered outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= ST_IDLE;
      channel_r <= {CH_W{1'b0}};
      data_r    <= {(N_CHANNELS*DATA_WIDTH){1'b0}};
      valid_r   <= {N_CHANNELS{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      for (int c = 0; c < N_CHANNELS; c++) begin
        ptr_r[c] <= {PTR_W{1'b0}};
      end
    end else begin
      state_r <= state_next_s;
      valid_r <= {N_CHANNELS{1'b0}};
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
      if (load_s) begin
        channel_r <= {CH_W{1'b0}};
        for (int c = 0; c < N_CHANNELS; c++) begin
          ptr_r[c] <= {PTR_W{1'b0}};
        end
      end else if (advance_s) begin
        channel_r <= channel_next_s;
      end else if (capture_s) begin
        // Pointers saturate at the plane size rather than wrapping.
        for (int c = 0; c < N_CHANNELS; c++) begin
          if (channel_r == CH_W'(c)) begin
            data_r[c*DATA_WIDTH +: DATA_WIDTH] <= ram_data_i;
            valid_r[c]                         <= 1'b1;
            if (ptr_r[c] != PTR_W'(N_PIX)) begin
              ptr_r[c] <= ptr_r[c] + PTR_W'(1);
            end
          end
        end
      end
    end
  end

  assign ram_rden_o   = rd_s;
  assign ram_addr_o   = rd_s ? addr_s : {ADDR_WIDTH{1'b0}};
  assign data_o       = data_r;
  assign data_valid_o = valid_r;
  assign channel_o    = channel_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;

endmodule

// File: doc/channel_feed_scheduler.md
CHANNEL_FEED_SCHEDULER -- requirements
Module: channel_feed_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: RAM address width.
REQ-002 Parameter DATA_WIDTH, default 32: pixel word width (Q16.16).
REQ-003 Parameter N_ROWS, default 100: image rows per channel.
REQ-004 Parameter N_COLS, default 100: image columns per channel.
REQ-005 Parameter N_CHANNELS, default 3: channel planes stored back-to-back in RAM; N_PIX = N_ROWS*N_COLS.
REQ-006 Port clock_i, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port reset_n_i, input, 1: asynchronous active-low reset.
REQ-008 Port start_i, input, 1: begin one frame transfer; sampled in IDLE only.
REQ-009 Port clear_i, input, 1: synchronous abort to IDLE.
REQ-010 Port hold_data_i, input, N_CHANNELS: bit c high = conv core refuses data for channel c.
REQ-011 Port ram_addr_o, output, ADDR_WIDTH: read address to a synchronous RAM with 1-cycle read latency.
REQ-012 Port ram_rden_o, output, 1: read-enable qualifying ram_addr_o.
REQ-013 Port ram_data_i, input, DATA_WIDTH: RAM read data, valid the cycle after ram_rden_o.
REQ-014 Port data_o, output, N_CHANNELS*DATA_WIDTH: per-channel registered pixel; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-015 Port data_valid_o, output, N_CHANNELS: one-cycle strobe per channel marking a new data_o word.
REQ-016 Port channel_o, output, $clog2(N_CHANNELS)+1: channel currently served.
REQ-017 Port busy_o, output, 1: high in any state other than IDLE.
REQ-018 Port done_o, output, 1: one-cycle pulse at frame completion.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, CAPTURE, DONE.
REQ-020 IDLE: start_i=1 -> all per-channel pointers ptr[c] set to 0, channel set to 0, next state FETCH; otherwise remain.
REQ-021 FETCH, all channels exhausted (ptr[c]==N_PIX for every c) -> DONE, no read issued.
REQ-022 FETCH, current channel exhausted or hold_data_i[channel]=1 -> channel advances to (channel+1) mod N_CHANNELS, remain FETCH, ram_rden_o=0.
REQ-023 FETCH otherwise: ram_rden_o=1, ram_addr_o = channel*N_PIX + ptr[channel] (combinational from registered state), next state CAPTURE.
REQ-024 CAPTURE: data_o[channel] <= ram_data_i, data_valid_o[channel] <= 1 for exactly one cycle (visible the cycle after CAPTURE), ptr[channel] incremented, next state FETCH; channel unchanged.
REQ-025 Throughput: one pixel per 2 cycles while a channel is not held; no hold bit is sampled in CAPTURE.
REQ-026 Channel switching SHALL occur only on hold or exhaustion; an unheld channel is drained contiguously.
REQ-027 data_o words of non-strobed channels SHALL hold their last value.
REQ-028 DONE: done_o=1 for one cycle, next state IDLE.
REQ-029 Pointer width $clog2(N_PIX+1); pointers SHALL saturate at N_PIX and never wrap.
REQ-030 start_i outside IDLE SHALL be ignored.
REQ-031 clear_i=1 in any state -> next state IDLE, ram_rden_o=0 that cycle, no data_valid_o strobe generated, pointers retained; clear_i wins over start_i.
REQ-032 N_CHANNELS*N_PIX > 2^ADDR_WIDTH is a configuration error flagged at elaboration.

Reset
REQ-033 reset_n_i=0 asynchronously forces IDLE, ptr[*]=0, channel_o=0, data_o=0, data_valid_o=0, ram_rden_o=0, ram_addr_o=0, busy_o=0, done_o=0, including mid-transfer.

Verification (bench: N_ROWS=N_COLS=4, N_CHANNELS=3, N_PIX=16)
REQ-034 Reset asserted mid-CAPTURE -> all outputs 0 same cycle; after release, no strobe until start_i.
REQ-035 start_i, hold_data_i=0 -> addresses 0..15 every 2 cycles on channel 0, then 16..31, then 32..47; 48 strobes, done_o once, 97-99 cycles total.
REQ-036 hold_data_i[0] raised after 3rd strobe -> next address 16, channel_o=1; ch0 later resumes at address 3.
REQ-037 hold_data_i=3'b111 from start -> no ram_rden_o, channel_o cycles 0,1,2; releasing bit 2 -> next address 32.
REQ-038 clear_i after 5 strobes -> busy_o=0 next cycle; start_i then resumes ch0 at address 0 (pointers reset by start).
REQ-039 start_i pulsed during FETCH -> no effect on addresses or pointers; single done_o per frame.
